// File: rtl/gf2m131_pkg.sv
// rtl/gf2m131_pkg.sv - shared constants and state encoding for the GF(2^131) datapath
package gf2m131_pkg;

  localparam int M     = 131;
  localparam int IN_W  = 2 * M + 1;
  localparam int NTAPS = 4;

  // Exponents of the low-order terms of P(x) = x^131 + x^13 + x^2 + x + 1
  localparam int TAPS [NTAPS] = '{13, 2, 1, 0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/gf2m_fold_segment.sv
// rtl/gf2m_fold_segment.sv - one DIGIT-wide top-down fold of the working polynomial
module gf2m_fold_segment
  import gf2m131_pkg::*;
#(
  parameter int M     = 131,
  parameter int DIGIT = 33,
  localparam int W    = 2 * M + 1,
  localparam int NSEG = (M + 1) / DIGIT,
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1
) (
  input  logic [W-1:0]  w_i,
  input  logic [CW-1:0] seg_i,
  output logic [W-1:0]  w_o
);

  localparam logic [W-1:0] DMASK = {{(W - DIGIT){1'b0}}, {DIGIT{1'b1}}};

  int           lo;
  logic [W-1:0] seg_bits;
  logic [W-1:0] base;

  // Clear segment k and add its value times (x^13 + x^2 + x + 1) at x^(p-M);
  // every landing bit is below the segment, so the whole segment folds at once.
  always_comb begin
    lo       = W - (int'(seg_i) + 1) * DIGIT;
    seg_bits = (w_i >> lo) & DMASK;
    base     = seg_bits << (lo - M);
    w_o      = w_i & ~(DMASK << lo);
    for (int t = 0; t < NTAPS; t++) begin
      w_o = w_o ^ (base << TAPS[t]);
    end
  end

endmodule

// File: rtl/gf2m131_reduce_seq.sv
// rtl/gf2m131_reduce_seq.sv - sequential mod-P reducer, DIGIT coefficients per cycle
module gf2m131_reduce_seq
  import gf2m131_pkg::*;
#(
  parameter int M     = 131,
  parameter int DIGIT = 33
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*M:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M-1:0]   out_data,
  output logic           busy
);

  localparam int NSEG = (M + 1) / DIGIT;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  if (((M + 1) % DIGIT) != 0 || DIGIT > M - 13) begin : g_bad_digit
    $error("DIGIT must divide M+1 and be at most M-13");
  end

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2*M:0]    w_q;
  logic [2*M:0]    w_fold;
  logic            out_valid_q;
  logic [M-1:0]    out_data_q;
  logic            busy_q;
  logic            in_fire;
  logic            out_fire;

  gf2m_fold_segment #(
    .M     (M),
    .DIGIT (DIGIT)
  ) u_fold (
    .w_i   (w_q),
    .seg_i (cnt_q),
    .w_o   (w_fold)
  );

  // A new operand is taken when idle, or in HOLD in the same cycle the result leaves
  assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid_q & out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

  // Control FSM, fold counter, working register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            w_q     <= in_data;
            cnt_q   <= '0;
            state_q <= FOLD;
            busy_q  <= 1'b1;
          end
        end
        FOLD: begin
          w_q <= w_fold;
          if (cnt_q == CW'(NSEG - 1)) begin
            state_q     <= HOLD;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= w_fold[M-1:0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            if (in_fire) begin
              w_q     <= in_data;
              cnt_q   <= '0;
              state_q <= FOLD;
              busy_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m131_reduce_seq.sv
// tb/tb_gf2m131_reduce_seq.sv - randomized and directed checks of the mod-P reducer
module tb_gf2m131_reduce_seq;

  localparam int NRAND = 3000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [262:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [130:0] out_data;
  logic         busy;

  int n_checks;
  int n_errors;

  gf2m131_reduce_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [262:0] got, input logic [262:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Schoolbook long division by P(x), highest degree first
  function automatic logic [130:0] ref_reduce(input logic [262:0] a);
    logic [262:0] r;
    logic [262:0] p;
    r = a;
    p = '0;
    p[131] = 1'b1; p[13] = 1'b1; p[2] = 1'b1; p[1] = 1'b1; p[0] = 1'b1;
    for (int i = 262; i >= 131; i--) begin
      if (r[i]) r = r ^ (p << (i - 131));
    end
    return r[130:0];
  endfunction

  function automatic logic [262:0] rand_op();
    logic [287:0] tmp;
    tmp = '0;
    for (int i = 0; i < 9; i++) tmp = {tmp[255:0], $urandom()};
    return tmp[262:0];
  endfunction

  // Called at the negedge after the input transfer edge
  task automatic wait_result(input string tag, input logic [130:0] exp);
    int t;
    int bcnt;
    t = 0;
    bcnt = 0;
    while (!out_valid && t < 20) begin
      if (busy) bcnt++;
      t++;
      @(negedge clk);
    end
    check({tag, "_latency"}, t, 4);
    check({tag, "_busy_cycles"}, bcnt, 4);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_data"}, out_data, exp);
  endtask

  task automatic run_one(input string tag, input logic [262:0] din, input logic [130:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = din;
    out_ready = 1'b0;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(tag, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drained"}, out_valid, 0);
  endtask

  initial begin
    logic [262:0] d;
    logic [262:0] d2;
    logic [130:0] held;
    logic [130:0] exp_q[$];
    logic [262:0] pend;
    logic         have_pend;
    int           sent;
    int           got;
    int           cyc;
    logic         in_f;
    logic         out_f;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;

    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Directed operands
    d = '0; d[131] = 1'b1;
    run_one("x131", d, 131'h2007);
    d = '0; d[262] = 1'b1;
    run_one("x262", d, 131'h4000015);
    d = 263'h1234_5678;
    run_one("small", d, 131'h1234_5678);
    d = '1;
    run_one("all_ones", d, ref_reduce(d));

    // Output stall in HOLD, then simultaneous output and input transfer
    d  = rand_op();
    d2 = rand_op();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("stall_a", ref_reduce(d));
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, held);
      check("stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d2;
    #1;
    check("b2b_in_ready", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_valid_drop", out_valid, 0);
    check("b2b_busy", busy, 1);
    // this negedge is already one cycle into the fold; wait_result counts from here
    wait_result("b2b", ref_reduce(d2));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the second fold cycle
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rand_op();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_fold_valid", out_valid, 0);
    check("rst_fold_in_ready", in_ready, 1);
    check("rst_fold_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("rst_fold_no_output", out_valid, 0);

    // Reset while holding a result
    d = rand_op();
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("pre_rst_hold", ref_reduce(d));
    rst_n = 1'b0;
    #1;
    check("rst_hold_valid", out_valid, 0);
    check("rst_hold_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d = rand_op();
    run_one("after_rst", d, ref_reduce(d));

    // Random stream with producer and consumer stalls
    sent = 0;
    got = 0;
    cyc = 0;
    have_pend = 1'b0;
    pend = '0;
    while (got < NRAND && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (!have_pend && sent < NRAND && ($urandom_range(0, 3) != 0)) begin
        pend = rand_op();
        if ($urandom_range(0, 15) == 0) pend = '1;
        have_pend = 1'b1;
      end
      in_valid  = have_pend;
      in_data   = pend;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      out_f = out_valid & out_ready;
      in_f  = in_valid & in_ready;
      if (out_f) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_output", 1, 0);
        end else begin
          check("rand_data", out_data, exp_q.pop_front());
        end
        got++;
      end
      if (in_f) begin
        exp_q.push_back(ref_reduce(pend));
        sent++;
        have_pend = 1'b0;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_count", got, NRAND);
    check("rand_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
